sb_regfile: RTL and testbench
=============================

// Module: sb_regfile
// PURPOSE
//  Parametrised pipeline register file with integrated scoreboard; successor to the 2R/1W regfile.
//  NRD async read ports, one sync write port, r0 hardwired to zero, per-register pending bits.
//  Issue stage marks a destination pending; writeback clears it.
//  Read ports report busy so decode stalls instead of relying on redirect alone.
// PARAMETERS
//  DW   32  data width
//  AW   5   register address width; NREG = 2**AW registers
//  NRD  2   number of read ports (1..4)
// PORTS
//  clk       in   1       clock; all state updates on rising edge
//  reset     in   1       synchronous, active-low reset
//  rd_addr   in   NRD*AW  read addresses, port i at [i*AW +: AW]
//  rd_data   out  NRD*DW  read data, port i at [i*DW +: DW]
//  rd_busy   out  NRD     1 = addressed register pending (never for r0)
//  wr_en     in   1       writeback strobe
//  wr_addr   in   AW      writeback register
//  wr_data   in   DW      writeback value
//  iss_en    in   1       issue request: mark iss_addr pending
//  iss_addr  in   AW      destination of issuing instruction
//  iss_ok    out  1       issue accepted this cycle
//  flush     in   1       clear all pending bits (branch mispredict / exception)
//  pend_cnt  out  AW+1    number of registers currently pending
// BEHAVIOUR
//  Reset (reset==0 at edge): all registers 0, all pending 0. Reset beats every other input.
//   Outputs after reset: rd_data=0, rd_busy=0, iss_ok=iss_en, pend_cnt=0.
//  Read: combinational, zero latency. rd_addr==0 -> rd_data=0, rd_busy=0.
//  Write: wr_en && wr_addr!=0 -> reg[wr_addr]<=wr_data and pending[wr_addr]<=0 at edge.
//   wr_addr==0 ignored. Write to a non-pending reg is legal.
//  Issue: iss_ok = iss_en && (iss_addr==0 || !pending[iss_addr] || clear_now).
//   clear_now = wr_en && wr_addr==iss_addr. This is WAW protection; at most one writer in flight per reg.
//   iss_ok && iss_addr!=0 -> pending[iss_addr]<=1. iss_addr==0 is accepted, sets nothing.
//   iss_en && !iss_ok: no state change; the requester retries.
//  Same-cycle write+issue, same reg: data written, pending ends 1 (issue wins).
//  Flush: all pending<=0, and any issue that cycle is dropped (iss_ok forced 0).
//   A write in the same cycle still updates data.
//  rd_busy[i] = pending[rd_addr_i], evaluated before this cycle's edge.
//   Without the bypass feature, rd_busy stays 1 during the writeback cycle.
//  pend_cnt = popcount(pending); registered, consistent with the pending vector after each edge.
// CONFIGURATION
//  SB_REGFILE_BYPASS_EN defined:
//   wr_en && wr_addr==rd_addr_i && wr_addr!=0 -> rd_data_i = wr_data.
//   rd_busy[i] = 0 for that port in that cycle. Write-through; decode saves one stall cycle.
//  Undefined: rd_data shows the old register value until the edge; rd_busy stays 1 that cycle.
// STRUCTURE
//  Package sb_regfile_pkg holds:
//   defaults for DW, AW, NRD
//   the REG_ZERO constant
//   the port slice helper function (index -> bit offset)
//  Sub-module sb_scoreboard owns:
//   pending vector, iss_ok logic, flush handling, pend_cnt
//   inputs: set (iss), clear (wr), flush
//  sb_regfile holds the data array, read muxes and the optional bypass.
// TESTING
//  1 Reset: write r3=7, assert reset=0 one cycle -> rd r3 = 0, pend_cnt=0, rd_busy=0.
//  2 Issue/writeback: iss r5 -> rd_busy=1 next cycle and pend_cnt=1.
//    Then wr r5=0x1234 -> next cycle rd_data=0x1234, rd_busy=0, pend_cnt=0.
//  3 WAW: iss r5, then iss r5 again -> iss_ok=0 and pend_cnt stays 1.
//    Same cycle as wr r5 -> iss_ok=1 and pending stays 1.
//  4 r0: wr r0=0xFFFF, iss r0 -> iss_ok=1, rd r0=0, rd_busy=0, pend_cnt=0.
//  5 Flush: iss r1, r2, r3 -> pend_cnt=3.
//    Then flush with iss r4 -> iss_ok=0, pend_cnt=0 next cycle.
//  6 Bypass: iss r9, then wr r9=42 while rd port1=r9.
//    BYPASS_EN: rd_data=42, busy=0 same cycle. Else: old value, busy=1.

Source files
------------

// File: rtl/sb_regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
// Optional write-through bypass is selected by SB_REGFILE_BYPASS_EN.
package sb_regfile_pkg;

  localparam int DW_DEFAULT  = 32;
  localparam int AW_DEFAULT  = 5;
  localparam int NRD_DEFAULT = 2;

  // Architectural zero register: reads as 0, never pending, writes ignored.
  localparam int REG_ZERO = 0;

  // Bit offset of port 'index' inside a flattened bus of 'width'-bit fields.
  function automatic int slice_lo(input int index, input int width);
    return index * width;
  endfunction

endpackage

// File: rtl/sb_scoreboard.sv
// Per-register pending bits: issue sets, writeback clears, flush clears all.
// Also decides whether an issue is accepted and keeps a registered popcount.
module sb_scoreboard
  import sb_regfile_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic              flush,
  output logic              set_ok,
  output logic [2**AW-1:0]  pending,
  output logic [AW:0]       pend_cnt
);

  logic [2**AW-1:0] pend_nxt;
  logic [AW:0]      cnt_nxt;
  logic             clear_now;

  // A writeback retiring the same register this cycle frees it for a new writer.
  assign clear_now = clr_en && (clr_addr == set_addr);
  assign set_ok    = set_en && !flush &&
                     ((set_addr == AW'(REG_ZERO)) || !pending[set_addr] || clear_now);

  always_comb begin
    pend_nxt = pending;
    if (flush) begin
      pend_nxt = '0;
    end else begin
      if (clr_en) pend_nxt[clr_addr] = 1'b0;
      if (set_ok && (set_addr != AW'(REG_ZERO))) pend_nxt[set_addr] = 1'b1;
    end
    cnt_nxt = '0;
    for (int i = 0; i < 2**AW; i++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/sb_regfile.sv
// Register file with NRD async read ports, one sync write port, r0 tied to zero
// and an integrated scoreboard. Define SB_REGFILE_BYPASS_EN for write-through reads.
module sb_regfile
  import sb_regfile_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int AW  = AW_DEFAULT,
  parameter int NRD = NRD_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              iss_ok,
  input  logic              flush,
  output logic [AW:0]       pend_cnt
);

  localparam int NREG = 2**AW;

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] pending;

  sb_scoreboard #(.AW(AW)) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (iss_en),
    .set_addr (iss_addr),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .flush    (flush),
    .set_ok   (iss_ok),
    .pending  (pending),
    .pend_cnt (pend_cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != AW'(REG_ZERO))) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    a       = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      a = rd_addr[slice_lo(i, AW) +: AW];
      rd_data[slice_lo(i, DW) +: DW] = regs[a];
      rd_busy[i] = pending[a];
      if (a == AW'(REG_ZERO)) begin
        rd_data[slice_lo(i, DW) +: DW] = '0;
        rd_busy[i] = 1'b0;
      end
`ifdef SB_REGFILE_BYPASS_EN
      // Forward the retiring value so decode need not wait for the edge.
      if (wr_en && (wr_addr == a) && (a != AW'(REG_ZERO))) begin
        rd_data[slice_lo(i, DW) +: DW] = wr_data;
        rd_busy[i] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sb_regfile.sv
// Self-checking bench for sb_regfile: directed vector table, a bypass sequence,
// then random traffic checked against an array-based reference model.
module tb_sb_regfile;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              iss_ok;
  logic              flush;
  logic [AW:0]       pend_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_regs [32];
  bit            m_pend [32];

  sb_regfile #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .iss_ok   (iss_ok),
    .flush    (flush),
    .pend_cnt (pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic        fl;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic        ok;
    logic [31:0] d0;
    logic        b0;
    logic [31:0] d1;
    logic        b1;
    logic [5:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_n, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic ie, input logic [4:0] ia,
                              input logic fl, input logic [4:0] r0, input logic [4:0] r1,
                              input logic ok, input logic [31:0] d0, input logic b0,
                              input logic [31:0] d1, input logic b1, input logic [5:0] cnt);
    vec_t v;
    v.rst_n = rst_n; v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia; v.fl = fl;
    v.r0 = r0; v.r1 = r1; v.ok = ok; v.d0 = d0; v.b0 = b0; v.d1 = d1; v.b1 = b1; v.cnt = cnt;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rs, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic ie, input logic [4:0] ia,
                               input logic fl, input logic [4:0] r0, input logic [4:0] r1);
    @(negedge clk);
    reset    = rs;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    iss_en   = ie;
    iss_addr = ia;
    flush    = fl;
    rd_addr  = {r1, r0};
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic ok, input logic [31:0] d0,
                             input logic b0, input logic [31:0] d1, input logic b1,
                             input logic [5:0] cnt);
    cmp({tag, ".iss_ok"},   32'(iss_ok),        32'(ok));
    cmp({tag, ".rd_data0"}, rd_data[31:0],      d0);
    cmp({tag, ".rd_busy0"}, 32'(rd_busy[0]),    32'(b0));
    cmp({tag, ".rd_data1"}, rd_data[63:32],     d1);
    cmp({tag, ".rd_busy1"}, 32'(rd_busy[1]),    32'(b1));
    cmp({tag, ".pend_cnt"}, 32'(pend_cnt),      32'(cnt));
  endtask

  // Reference model: what a reader sees for register a given current stored state.
  function automatic void model_read(input logic [4:0] a, output logic [31:0] d, output logic b);
    if (a == 5'd0) begin
      d = '0;
      b = 1'b0;
    end else begin
      d = m_regs[a];
      b = m_pend[a];
`ifdef SB_REGFILE_BYPASS_EN
      if (wr_en && wr_addr == a) begin
        d = wr_data;
        b = 1'b0;
      end
`endif
    end
  endfunction

  function automatic logic model_ok();
    return iss_en && !flush &&
           (iss_addr == 5'd0 || !m_pend[iss_addr] || (wr_en && wr_addr == iss_addr));
  endfunction

  function automatic logic [5:0] model_cnt();
    int c = 0;
    foreach (m_pend[i]) c += int'(m_pend[i]);
    return 6'(c);
  endfunction

  task automatic checkModel(input string tag);
    logic [31:0] d0, d1;
    logic        b0, b1;
    model_read(rd_addr[4:0], d0, b0);
    model_read(rd_addr[9:5], d1, b1);
    checkOutput(tag, model_ok(), d0, b0, d1, b1, model_cnt());
  endtask

  task automatic advance();
    logic ok;
    ok = model_ok();
    @(posedge clk);
    if (!reset) begin
      foreach (m_regs[i]) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
      if (flush) begin
        foreach (m_pend[i]) m_pend[i] = 1'b0;
      end else begin
        if (wr_en) m_pend[wr_addr] = 1'b0;
        if (ok && iss_addr != 5'd0) m_pend[iss_addr] = 1'b1;
      end
    end
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0; rd_addr = '0;

    repeat (2) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
      advance();
    end

    // rst_n we wa wd ie ia fl r0 r1 | ok d0 b0 d1 b1 cnt  (outputs sampled before the edge)
    vecs.push_back(mk(1, 1, 3, 32'd7,     0, 0, 0, 1, 0, 0, 32'd0,     0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'd0,     0, 0, 0, 3, 0, 0, 32'd7,     0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'd0,     0, 0, 0, 3, 0, 0, 32'd0,     0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'd0,     1, 5, 0, 5, 0, 1, 32'd0,     0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'd0,     0, 0, 0, 5, 0, 0, 32'd0,     1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 32'd0,     1, 5, 0, 5, 0, 0, 32'd0,     1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 5, 32'h1234,  1, 5, 0, 6, 0, 1, 32'd0,     0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 32'd0,     0, 0, 0, 5, 0, 0, 32'h1234,  1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 5, 32'h1234,  0, 0, 0, 7, 0, 0, 32'd0,     0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 32'd0,     0, 0, 0, 5, 0, 0, 32'h1234,  0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 32'hFFFF,  1, 0, 0, 0, 0, 1, 32'd0,     0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'd0,     0, 0, 0, 0, 0, 0, 32'd0,     0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'd0,     1, 1, 0, 1, 0, 1, 32'd0,     0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'd0,     1, 2, 0, 1, 0, 1, 32'd0,     1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 32'd0,     1, 3, 0, 2, 0, 1, 32'd0,     1, 0, 0, 2));
    vecs.push_back(mk(1, 0, 0, 32'd0,     1, 4, 1, 3, 4, 0, 32'd0,     1, 0, 0, 3));
    vecs.push_back(mk(1, 0, 0, 32'd0,     0, 0, 0, 1, 4, 0, 32'd0,     0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'd0,     1, 6, 0, 6, 0, 1, 32'd0,     0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 6, 32'hAB,    0, 0, 1, 7, 0, 0, 32'd0,     0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 32'd0,     0, 0, 0, 6, 0, 0, 32'hAB,    0, 0, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ie,
                    vecs[i].ia, vecs[i].fl, vecs[i].r0, vecs[i].r1);
      checkOutput($sformatf("vec%0d", i), vecs[i].ok, vecs[i].d0, vecs[i].b0,
                  vecs[i].d1, vecs[i].b1, vecs[i].cnt);
      advance();
    end

    // Writeback of a pending register observed on the same cycle through port 1.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd9);
    checkOutput("byp_issue", 1'b1, 32'd0, 1'b0, 32'd0, 1'b0, 6'd1 - 6'd1);
    advance();
    applyStimulus(1'b1, 1'b1, 5'd9, 32'd42, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9);
`ifdef SB_REGFILE_BYPASS_EN
    checkOutput("byp_wb", 1'b0, 32'd0, 1'b0, 32'd42, 1'b0, 6'd1);
`else
    checkOutput("byp_wb", 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 6'd1);
`endif
    advance();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9);
    checkOutput("byp_after", 1'b0, 32'd0, 1'b0, 32'd42, 1'b0, 6'd0);
    advance();

    // Random traffic over a narrow address window to force collisions.
    for (int n = 0; n < 500; n++) begin
      logic [4:0] wa, ia, r0, r1;
      wa = 5'($urandom_range(0, 7));
      ia = 5'($urandom_range(0, 7));
      r0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 3) == 0) ? ia : 5'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 79) != 0), 1'($urandom_range(0, 1)), wa, $urandom(),
                    ($urandom_range(0, 3) != 0), ia, ($urandom_range(0, 19) == 0), r0, r1);
      checkModel($sformatf("rand%0d", n));
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
